// File: rtl/qlearn_pkg.sv
// rtl/qlearn_pkg.sv - shared widths, FSM state type and saturation helper for the Q-update sequencer
package qlearn_pkg;

    localparam int DEF_STATE_W = 6;
    localparam int DEF_ACT_W   = 2;
    localparam int DEF_ADDR_W  = DEF_STATE_W + DEF_ACT_W;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_FRAC_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DRAIN,
        ST_CALC,
        ST_WR
    } qstate_t;

    // Clamp a two-bit-wider intermediate back into the signed Q range.
    function automatic logic [DEF_DATA_W-1:0] sat_data(input logic signed [DEF_DATA_W+1:0] x);
        logic signed [DEF_DATA_W+1:0] hi;
        logic signed [DEF_DATA_W+1:0] lo;
        hi = {3'b000, {(DEF_DATA_W-1){1'b1}}};
        lo = {3'b111, {(DEF_DATA_W-1){1'b0}}};
        if (x > hi) begin
            return {1'b0, {(DEF_DATA_W-1){1'b1}}};
        end else if (x < lo) begin
            return {1'b1, {(DEF_DATA_W-1){1'b0}}};
        end
        return x[DEF_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/qmax_tracker.sv
// rtl/qmax_tracker.sv - running signed max/argmax over a stream of next-state Q values
module qmax_tracker
    import qlearn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACT_W  = DEF_ACT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] max_val,
    output logic [ACT_W-1:0]  max_idx
);

    logic             first;
    logic [ACT_W-1:0] idx;

    // Strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            first   <= 1'b1;
            idx     <= '0;
            max_val <= '0;
            max_idx <= '0;
        end else if (clear) begin
            first <= 1'b1;
            idx   <= '0;
        end else if (valid) begin
            if (first || ($signed(data) > $signed(max_val))) begin
                max_val <= data;
                max_idx <= idx;
            end
            first <= 1'b0;
            idx   <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/qupdate_ctrl.sv
// rtl/qupdate_ctrl.sv - one tabular Q-learning update per transition; optional QUPDATE_TERMINAL_EN
module qupdate_ctrl
    import qlearn_pkg::*;
#(
    parameter int STATE_W     = DEF_STATE_W,
    parameter int ACT_W       = DEF_ACT_W,
    parameter int ADDR_W      = STATE_W + ACT_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ALPHA_SHIFT = 3,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [STATE_W-1:0] i_state,
    input  logic [ACT_W-1:0]   i_action,
    input  logic [DATA_W-1:0]  i_reward,
    input  logic [STATE_W-1:0] i_next_state,
`ifdef QUPDATE_TERMINAL_EN
    input  logic               i_terminal,
`endif
    output logic [ADDR_W-1:0]  o_addr_r,
    output logic               o_read_en,
    input  logic [DATA_W-1:0]  i_qdata,
    output logic [ADDR_W-1:0]  o_addr_w,
    output logic               o_write_en,
    output logic [DATA_W-1:0]  o_wdata,
    output logic               o_done,
    output logic [ACT_W-1:0]   o_max_act
);

    localparam int NUM_ACT = 1 << ACT_W;
    localparam int CNT_W   = ACT_W + 1;
    localparam int EXT_W   = DATA_W + 2;

    qstate_t state, nxt;

    logic [CNT_W-1:0]   rd_cnt;
    logic [STATE_W-1:0] s_reg, ns_reg;
    logic [ACT_W-1:0]   a_reg;
    logic [DATA_W-1:0]  r_reg, q_reg;
    logic [DATA_W-1:0]  max_val;
    logic [ACT_W-1:0]   max_idx;
    logic               accept, trk_valid;

    logic signed [EXT_W-1:0] m_ext, q_ext, r_ext, g, td, u;

`ifdef QUPDATE_TERMINAL_EN
    logic term_reg;
`endif

    always_comb begin
        nxt        = state;
        o_ready    = 1'b0;
        o_read_en  = 1'b0;
        o_write_en = 1'b0;
        o_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) nxt = ST_RD;
            end
            ST_RD: begin
                o_read_en = 1'b1;
                if (rd_cnt == CNT_W'(NUM_ACT)) nxt = ST_DRAIN;
            end
            ST_DRAIN: nxt = ST_CALC;
            ST_CALC:  nxt = ST_WR;
            ST_WR: begin
                o_write_en = 1'b1;
                o_done     = 1'b1;
                nxt        = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    assign accept = i_valid && (state == ST_IDLE);
    // Read issued at count k returns at count k+1; count 0 is Q(s,a), the rest are Q(s',*).
    assign trk_valid = ((state == ST_RD) && (rd_cnt >= CNT_W'(2))) || (state == ST_DRAIN);

    qmax_tracker #(.DATA_W(DATA_W), .ACT_W(ACT_W)) u_max (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (accept),
        .valid   (trk_valid),
        .data    (i_qdata),
        .max_val (max_val),
        .max_idx (max_idx)
    );

    always_comb begin
`ifdef QUPDATE_TERMINAL_EN
        m_ext = term_reg ? '0 : {{2{max_val[DATA_W-1]}}, max_val};
`else
        m_ext = {{2{max_val[DATA_W-1]}}, max_val};
`endif
        q_ext = {{2{q_reg[DATA_W-1]}}, q_reg};
        r_ext = {{2{r_reg[DATA_W-1]}}, r_reg};
        g     = m_ext - (m_ext >>> GAMMA_SHIFT);
        td    = r_ext + g - q_ext;
        u     = q_ext + (td >>> ALPHA_SHIFT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            rd_cnt    <= '0;
            s_reg     <= '0;
            a_reg     <= '0;
            ns_reg    <= '0;
            r_reg     <= '0;
            q_reg     <= '0;
            o_addr_r  <= '0;
            o_addr_w  <= '0;
            o_wdata   <= '0;
            o_max_act <= '0;
`ifdef QUPDATE_TERMINAL_EN
            term_reg  <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (accept) begin
                s_reg    <= i_state;
                a_reg    <= i_action;
                ns_reg   <= i_next_state;
                r_reg    <= i_reward;
                rd_cnt   <= '0;
                o_addr_r <= {i_state, i_action};
`ifdef QUPDATE_TERMINAL_EN
                term_reg <= i_terminal;
`endif
            end
            if (state == ST_RD) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt < CNT_W'(NUM_ACT)) o_addr_r <= {ns_reg, rd_cnt[ACT_W-1:0]};
                if (rd_cnt == CNT_W'(1)) q_reg <= i_qdata;
            end
            if (state == ST_CALC) begin
                o_wdata   <= sat_data(u);
                o_addr_w  <= {s_reg, a_reg};
                o_max_act <= max_idx;
            end
        end
    end

endmodule
